// File: rtl/ibex_pkg.sv
// Shared types for the packed-adder arbiter slice: ALU operators, arbiter states and defaults.
// The arbiter's round-robin pointer is built only when IBEX_PADD_ARB_RR_EN is defined.
package ibex_pkg;

    typedef enum logic [6:0] {
        ALU_ADD   = 7'd0,
        ALU_SUB   = 7'd1,
        ZPN_ADD16 = 7'd2,
        ZPN_SUB16 = 7'd3,
        ZPN_ADD8  = 7'd4,
        ZPN_SUB8  = 7'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } padd_arb_state_e;

    localparam int unsigned PaddArbMaxLockDefault = 4;
    // Wide enough for the largest legal MaxLock (15).
    localparam int unsigned PaddArbCntW = 4;

    function automatic padd_arb_state_e padd_arb_lock_state(input logic id);
        return id ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/ibex_padd_arb_grant.sv
// Combinational grant selection for the packed-adder arbiter.
// Produces a one-hot (or empty) grant from request valids, arbiter state and priority pointer.
module ibex_padd_arb_grant
    import ibex_pkg::*;
(
    input  logic [1:0]      valid_i,
    input  padd_arb_state_e state_i,
    input  logic            ptr_i,
    output logic [1:0]      grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (state_i)
            ARB: begin
                if (&valid_i) begin
                    grant_o = ptr_i ? 2'b10 : 2'b01;
                end else begin
                    grant_o = valid_i;
                end
            end
            // A locked owner keeps the adder; the other requester is stalled.
            LOCK0:   grant_o = {1'b0, valid_i[0]};
            LOCK1:   grant_o = {valid_i[1], 1'b0};
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ibex_padd_arbiter.sv
// Shares one packed adder between the ALU (id 0) and the multi-pass unit (id 1), with bounded locks.
// Define IBEX_PADD_ARB_RR_EN for a round-robin pointer; otherwise requester 0 has fixed priority.
module ibex_padd_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxLock = PaddArbMaxLockDefault
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0]            req_lock_i,
    input  alu_op_e [1:0]         req_operator_i,
    input  logic [1:0][32:0]      req_a_i,
    input  logic [1:0][32:0]      req_b_i,
    output logic [1:0]            rsp_valid_o,
    output logic [33:0]           rsp_result_o,
    output alu_op_e               operator_o,
    output logic [32:0]           adder_in_a_o,
    output logic [32:0]           adder_in_b_o,
    input  logic [33:0]           adder_result_ext_i
);

    localparam logic [PaddArbCntW-1:0] MaxLockCnt = PaddArbCntW'(MaxLock);

    padd_arb_state_e        state_q, state_d;
    logic [PaddArbCntW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]             grant;
    logic [1:0]             ready;
    logic                   xfer;
    logic                   win_id;
    logic                   lock_owner;
    logic                   ptr;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [33:0]            rsp_result_q;

    ibex_padd_arb_grant u_grant (
        .valid_i (req_valid_i),
        .state_i (state_q),
        .ptr_i   (ptr),
        .grant_o (grant)
    );

    // Flush blocks every handshake so nothing new is captured in that cycle.
    assign ready       = flush_i ? 2'b00 : grant;
    assign req_ready_o = ready;
    assign xfer        = |(ready & req_valid_i);
    assign win_id      = ready[1];
    assign lock_owner  = (state_q == LOCK1);

`ifdef IBEX_PADD_ARB_RR_EN
    logic ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (xfer && (state_q == ARB)) begin
            ptr_q <= ~win_id;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ARB: begin
                if (xfer && req_lock_i[win_id]) begin
                    state_d    = padd_arb_lock_state(win_id);
                    lock_cnt_d = PaddArbCntW'(1);
                end
            end
            LOCK0, LOCK1: begin
                if (xfer) begin
                    if (req_lock_i[lock_owner] && (lock_cnt_q < MaxLockCnt)) begin
                        lock_cnt_d = lock_cnt_q + PaddArbCntW'(1);
                    end else begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end
                end else if (!req_lock_i[lock_owner]) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
        if (flush_i) begin
            state_d    = ARB;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        operator_o   = ALU_ADD;
        adder_in_a_o = '0;
        adder_in_b_o = '0;
        if (ready[0]) begin
            operator_o   = req_operator_i[0];
            adder_in_a_o = req_a_i[0];
            adder_in_b_o = req_b_i[0];
        end else if (ready[1]) begin
            operator_o   = req_operator_i[1];
            adder_in_a_o = req_a_i[1];
            adder_in_b_o = req_b_i[1];
        end
    end

    assign rsp_valid_d = xfer ? ready : 2'b00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (xfer) begin
                rsp_result_q <= adder_result_ext_i;
            end
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;

    ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
    lock_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_cnt_q <= MaxLockCnt);
    lock_cnt_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB) |-> (lock_cnt_q == '0));

endmodule

// File: tb/tb_ibex_padd_arbiter.sv
// Self-checking bench for ibex_padd_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grants, locks and responses.
module tb_ibex_padd_arbiter;
    import ibex_pkg::*;

    localparam int unsigned MAXLOCK = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [1:0]      req_valid, req_lock, req_ready, rsp_valid;
    alu_op_e [1:0]   req_op;
    logic [1:0][32:0] req_a, req_b;
    logic [33:0]     rsp_result, adder_result;
    alu_op_e         operator;
    logic [32:0]     adder_in_a, adder_in_b;

    int checks = 0;
    int errors = 0;

    // Model state: lock owner (-1 none), transfers still allowed under the lock, priority pointer.
    int          m_owner;
    int          m_rem;
    logic        m_ptr;
    logic [1:0]  m_rsp_valid;
    logic [33:0] m_rsp_result;

    always #5 clk = ~clk;

    // Stand-in adder: operator code is folded in so a misrouted operator changes the result.
    assign adder_result = {1'b0, adder_in_a} + {1'b0, adder_in_b} + {27'd0, operator};

    ibex_padd_arbiter #(.MaxLock(MAXLOCK)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_lock_i         (req_lock),
        .req_operator_i     (req_op),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .rsp_valid_o        (rsp_valid),
        .rsp_result_o       (rsp_result),
        .operator_o         (operator),
        .adder_in_a_o       (adder_in_a),
        .adder_in_b_o       (adder_in_b),
        .adder_result_ext_i (adder_result)
    );

    function automatic logic [33:0] model_add(input alu_op_e op, input logic [32:0] a,
                                              input logic [32:0] b);
        return {1'b0, a} + {1'b0, b} + {27'd0, op};
    endfunction

    function automatic logic arb_pick();
`ifdef IBEX_PADD_ARB_RR_EN
        return m_ptr;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] model_ready();
        if (flush) return 2'b00;
        if (m_owner == 0) return {1'b0, req_valid[0]};
        if (m_owner == 1) return {req_valid[1], 1'b0};
        if (req_valid == 2'b11) return arb_pick() ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    function automatic logic [72:0] model_drive(input logic [1:0] r);
        if (r[0]) return {req_op[0], req_a[0], req_b[0]};
        if (r[1]) return {req_op[1], req_a[1], req_b[1]};
        return {ALU_ADD, 33'd0, 33'd0};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rem = 0;
        m_ptr = 1'b0;
        m_rsp_valid = 2'b00;
        m_rsp_result = '0;
    endtask

    task automatic model_commit(input logic [1:0] r);
        int n;
        if (flush) begin
            m_owner = -1;
            m_rem = 0;
            m_rsp_valid = 2'b00;
        end else if (r != 2'b00) begin
            n = r[1] ? 1 : 0;
            m_rsp_valid = r;
            m_rsp_result = model_add(req_op[n], req_a[n], req_b[n]);
            if (m_owner < 0) begin
                m_ptr = (n == 0);
                if (req_lock[n]) begin
                    m_owner = n;
                    m_rem = MAXLOCK - 1;
                end
            end else if (req_lock[n] && m_rem > 0) begin
                m_rem--;
            end else begin
                m_owner = -1;
                m_rem = 0;
            end
        end else begin
            m_rsp_valid = 2'b00;
            if (m_owner >= 0 && !req_lock[m_owner]) begin
                m_owner = -1;
                m_rem = 0;
            end
        end
    endtask

    task automatic rand_operands();
        for (int i = 0; i < 2; i++) begin
            req_op[i] = alu_op_e'(7'($urandom_range(0, 5)));
            req_a[i] = 33'({$urandom(), $urandom()});
            req_b[i] = 33'({$urandom(), $urandom()});
        end
    endtask

    // Samples DUT combinational outputs and model expectations, then advances one clock.
    // Entered shortly after a rising edge; returns 1 time unit after the next one.
    task automatic step(output logic [1:0] got_rdy, output logic [1:0] exp_rdy,
                        output logic [72:0] got_drv, output logic [72:0] exp_drv);
        #2;
        exp_rdy = model_ready();
        exp_drv = model_drive(exp_rdy);
        got_rdy = req_ready;
        got_drv = {operator, adder_in_a, adder_in_b};
        @(posedge clk);
        model_commit(exp_rdy);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid);
        end
        checks++;
        if (rsp_result !== 34'd0) begin
            errors++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result);
        end
        checks++;
        if ({operator, adder_in_a, adder_in_b} !== {ALU_ADD, 33'd0, 33'd0}) begin
            errors++; $display("FAIL reset_adder_drive: got %h/%h/%h want ADD/0/0",
                               operator, adder_in_a, adder_in_b);
        end
    endtask

    task automatic test_single();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        rand_operands();
        req_valid = 2'b01; req_lock = 2'b00; flush = 1'b0;
        req_op[0] = ZPN_ADD16; req_a[0] = 33'h0_0001_0002; req_b[0] = 33'h0_0003_0004;
        step(gr, er, gd, ed);
        checks++;
        if (gr !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", gr); end
        checks++;
        if (gd !== {ZPN_ADD16, 33'h0_0001_0002, 33'h0_0003_0004}) begin
            errors++; $display("FAIL single_drive: got %h want %h", gd, ed);
        end
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid);
        end
        checks++;
        if (rsp_result !== 34'h0_0004_0006 + {27'd0, ZPN_ADD16}) begin
            errors++; $display("FAIL single_rsp_result: got %h want %h", rsp_result,
                               34'h0_0004_0006 + {27'd0, ZPN_ADD16});
        end
        req_valid = 2'b00;
        step(gr, er, gd, ed);
        checks++;
        if (rsp_valid !== 2'b00 || rsp_result !== m_rsp_result) begin
            errors++; $display("FAIL single_rsp_hold: got %b/%h want 00/%h", rsp_valid,
                               rsp_result, m_rsp_result);
        end
    endtask

    task automatic test_contention();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        for (int i = 0; i < 4; i++) begin
            rand_operands();
            req_valid = 2'b11; req_lock = 2'b00; flush = 1'b0;
            step(gr, er, gd, ed);
            checks++;
            if (gr !== er) begin
                errors++; $display("FAIL contention_grant[%0d]: got %b want %b", i, gr, er);
            end
            checks++;
            if (rsp_valid !== er || rsp_result !== m_rsp_result) begin
                errors++; $display("FAIL contention_rsp[%0d]: got %b/%h want %b/%h", i,
                                   rsp_valid, rsp_result, er, m_rsp_result);
            end
        end
    endtask

    task automatic test_lock_burst();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        for (int i = 0; i < 8; i++) begin
            rand_operands();
            req_valid = (i == 0) ? 2'b10 : (i < 6) ? 2'b11 : 2'b01;
            req_lock = (i < 6) ? 2'b10 : 2'b00;
            flush = 1'b0;
            step(gr, er, gd, ed);
            checks++;
            if (gr !== er) begin
                errors++; $display("FAIL lock_burst_grant[%0d]: got %b want %b", i, gr, er);
            end
            checks++;
            if (rsp_valid !== m_rsp_valid || rsp_result !== m_rsp_result) begin
                errors++; $display("FAIL lock_burst_rsp[%0d]: got %b/%h want %b/%h", i,
                                   rsp_valid, rsp_result, m_rsp_valid, m_rsp_result);
            end
        end
    endtask

    task automatic test_lock_wait();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        logic [1:0] v_tab [5] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [1:0] l_tab [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        for (int i = 0; i < 5; i++) begin
            rand_operands();
            req_valid = v_tab[i]; req_lock = l_tab[i]; flush = 1'b0;
            step(gr, er, gd, ed);
            checks++;
            if (gr !== er) begin
                errors++; $display("FAIL lock_wait_grant[%0d]: got %b want %b", i, gr, er);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (gd !== {ALU_ADD, 33'd0, 33'd0}) begin
                    errors++; $display("FAIL lock_wait_idle_drive[%0d]: got %h want ADD/0/0",
                                       i, gd);
                end
            end
            if (i == 4) begin
                checks++;
                if (gr !== 2'b01) begin
                    errors++; $display("FAIL lock_wait_release: got %b want 01", gr);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        logic [1:0] v_tab [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
        logic [1:0] l_tab [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 4; i++) begin
            rand_operands();
            req_valid = v_tab[i]; req_lock = l_tab[i]; flush = (i == 1);
            step(gr, er, gd, ed);
            checks++;
            if (gr !== er) begin
                errors++; $display("FAIL flush_grant[%0d]: got %b want %b", i, gr, er);
            end
            checks++;
            if (rsp_valid !== m_rsp_valid || rsp_result !== m_rsp_result) begin
                errors++; $display("FAIL flush_rsp[%0d]: got %b/%h want %b/%h", i,
                                   rsp_valid, rsp_result, m_rsp_valid, m_rsp_result);
            end
            if (i == 1) begin
                checks++;
                if (gr !== 2'b00 || rsp_valid !== 2'b00) begin
                    errors++; $display("FAIL flush_kill: got ready %b rsp %b want 00/00",
                                       gr, rsp_valid);
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        for (int i = 0; i < 2; i++) begin
            rand_operands();
            req_valid = 2'b10; req_lock = 2'b10; flush = 1'b0;
            step(gr, er, gd, ed);
            checks++;
            if (gr !== er) begin
                errors++; $display("FAIL rst_burst_grant[%0d]: got %b want %b", i, gr, er);
            end
        end
        req_valid = 2'b00; req_lock = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_result !== 34'd0) begin
            errors++; $display("FAIL rst_async_clear: got %b/%h want 00/0", rsp_valid, rsp_result);
        end
        @(negedge clk) rst_n = 1'b1;
        step(gr, er, gd, ed);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL rst_no_rsp: got %b want 00", rsp_valid);
        end
        rand_operands();
        req_valid = 2'b11;
        step(gr, er, gd, ed);
        checks++;
        if (gr !== 2'b01) begin
            errors++; $display("FAIL rst_first_grant: got %b want 01", gr);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0] gr, er;
        logic [72:0] gd, ed;
        for (int i = 0; i < 400; i++) begin
            rand_operands();
            req_valid = 2'($urandom());
            req_lock = 2'($urandom());
            flush = ($urandom_range(0, 15) == 0);
            step(gr, er, gd, ed);
            checks++;
            if (gr !== er) begin
                errors++; $display("FAIL random_ready[%0d]: got %b want %b", i, gr, er);
            end
            checks++;
            if (gd !== ed) begin
                errors++; $display("FAIL random_drive[%0d]: got %h want %h", i, gd, ed);
            end
            checks++;
            if (rsp_valid !== m_rsp_valid) begin
                errors++; $display("FAIL random_rsp_valid[%0d]: got %b want %b", i, rsp_valid,
                                   m_rsp_valid);
            end
            checks++;
            if (rsp_result !== m_rsp_result) begin
                errors++; $display("FAIL random_rsp_result[%0d]: got %h want %h", i,
                                   rsp_result, m_rsp_result);
            end
        end
        flush = 1'b0;
        req_valid = 2'b00;
        req_lock = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 2'b00;
        req_lock = 2'b00;
        req_op = {ALU_ADD, ALU_ADD};
        req_a = '0;
        req_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
        test_contention();
        test_lock_burst();
        test_lock_wait();
        test_flush();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
